// File: rtl/spi_screen_clear.sv
// rtl/spi_screen_clear.sv - clears an ILI9341-style SPI panel to black in one write-only pass
// Issues CASET/PASET for the full window, RAMWR, then WIDTH*HEIGHT zero RGB565 pixels.
module spi_screen_clear #(
  parameter int DELAY  = 20,
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_mosi,
  output logic o_dc,
  output logic o_cs,
  output logic o_done
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int DW   = $clog2(DELAY + 2);
  localparam logic [15:0] WM1 = 16'(WIDTH - 1);
  localparam logic [15:0] HM1 = 16'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, WAIT, CASET, PASET, RAMWR, PIXELS, DONE} state_t;

  state_t          state;
  state_t          nxt_state;
  logic [DW-1:0]   wait_cnt;
  logic [2:0]      byte_idx;
  logic [2:0]      nxt_idx;
  logic [3:0]      bit_cnt;
  logic [7:0]      shift;
  logic [PW-1:0]   pix_cnt;
  logic [8:0]      nxt;
  logic            rearm;

  // {dc, byte} for one of the five bytes of an address-window command
  function automatic logic [8:0] win_byte(input logic [2:0] idx, input logic [7:0] cmd,
                                          input logic [15:0] last);
    case (idx)
      3'd0:    win_byte = {1'b0, cmd};
      3'd1,
      3'd2:    win_byte = {1'b1, 8'h00};
      3'd3:    win_byte = {1'b1, last[15:8]};
      default: win_byte = {1'b1, last[7:0]};
    endcase
  endfunction

  // Byte to load when the current byte finishes (or when WAIT expires)
  always_comb begin
    nxt       = 9'h000;
    nxt_state = state;
    nxt_idx   = 3'(byte_idx + 3'd1);
    case (state)
      WAIT: begin
        nxt       = {1'b0, 8'h2A};
        nxt_state = CASET;
        nxt_idx   = 3'd0;
      end
      CASET: begin
        if (byte_idx == 3'd4) begin
          nxt       = win_byte(3'd0, 8'h2B, HM1);
          nxt_state = PASET;
          nxt_idx   = 3'd0;
        end else begin
          nxt = win_byte(nxt_idx, 8'h2A, WM1);
        end
      end
      PASET: begin
        if (byte_idx == 3'd4) begin
          nxt       = {1'b0, 8'h2C};
          nxt_state = RAMWR;
          nxt_idx   = 3'd0;
        end else begin
          nxt = win_byte(nxt_idx, 8'h2B, HM1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      byte_idx <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      pix_cnt  <= '0;
      rearm    <= 1'b0;
      o_mosi   <= 1'b0;
      o_dc     <= 1'b0;
      o_cs     <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      // A held start only counts once; it must drop before another run is taken
      if (!i_start) rearm <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && !rearm) begin
            rearm    <= 1'b1;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == DW'(DELAY)) begin
            state    <= nxt_state;
            byte_idx <= nxt_idx;
            o_cs     <= 1'b0;
            o_mosi   <= nxt[7];
            o_dc     <= nxt[8];
            shift    <= {nxt[6:0], 1'b0};
            bit_cnt  <= '0;
          end else begin
            wait_cnt <= DW'(wait_cnt + 1'b1);
          end
        end
        CASET, PASET, RAMWR: begin
          if (bit_cnt != 4'd7) begin
            o_mosi  <= shift[7];
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (state == RAMWR) begin
            state   <= PIXELS;
            o_mosi  <= 1'b0;
            o_dc    <= 1'b1;
            bit_cnt <= '0;
            pix_cnt <= '0;
          end else begin
            state    <= nxt_state;
            byte_idx <= nxt_idx;
            o_mosi   <= nxt[7];
            o_dc     <= nxt[8];
            shift    <= {nxt[6:0], 1'b0};
            bit_cnt  <= '0;
          end
        end
        PIXELS: begin
          o_mosi <= 1'b0;
          o_dc   <= 1'b1;
          if (bit_cnt != 4'd15) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            bit_cnt <= '0;
            pix_cnt <= PW'(pix_cnt + 1'b1);
            if (pix_cnt == PW'(NPIX - 1)) begin
              state  <= DONE;
              o_cs   <= 1'b1;
              o_dc   <= 1'b0;
              o_done <= 1'b1;
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_screen_clear.sv
// tb/tb_spi_screen_clear.sv - scoreboard bench for spi_screen_clear
// Stimulus pushes the expected {dc,mosi} bit stream; a negedge monitor pops and compares.
module tb_spi_screen_clear;

  localparam int DELAY = 20;
  localparam int W     = 24;
  localparam int H     = 32;
  localparam int TOTAL = 88 + 16 * W * H;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mosi, dc, cs, done;

  int checks = 0;
  int failures = 0;
  int bits_seen = 0;
  int done_count = 0;
  bit prev_active = 0;
  logic [1:0] q[$];

  spi_screen_clear #(.DELAY(DELAY), .WIDTH(W), .HEIGHT(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_mosi(mosi), .o_dc(dc), .o_cs(cs), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic d, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) q.push_back({d, b[i]});
  endtask

  task automatic push_expected();
    push_byte(1'b0, 8'h2A); push_byte(1'b1, 8'h00); push_byte(1'b1, 8'h00);
    push_byte(1'b1, 8'h00); push_byte(1'b1, 8'h17);
    push_byte(1'b0, 8'h2B); push_byte(1'b1, 8'h00); push_byte(1'b1, 8'h00);
    push_byte(1'b1, 8'h00); push_byte(1'b1, 8'h1F);
    push_byte(1'b0, 8'h2C);
    for (int i = 0; i < 16 * W * H; i++) q.push_back(2'b10);
  endtask

  task automatic pulse_start_and_time();
    int k;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (!cs) begin k = n; break; end
    end
    check("first_bit_latency", k, DELAY + 1);
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_count == d0 && n < 13000) begin @(posedge clk); n++; end
    check("done_seen", done_count, d0 + 1);
  endtask

  task automatic do_run(input bit mid_pulse);
    int d0;
    int n;
    d0 = done_count;
    push_expected();
    pulse_start_and_time();
    if (mid_pulse) begin
      n = 0;
      while (bits_seen < 1000 && n < 2000) begin @(posedge clk); n++; end
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(d0);
    repeat (30) @(posedge clk);
    #1 check("idle_cs_after_run", cs, 1'b1);
  endtask

  // Monitor
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        bits_seen = 0;
        prev_active = 0;
      end else if (done) begin
        check("done_cs_high", cs, 1'b1);
        check("done_dc_low", dc, 1'b0);
        check("active_bits", bits_seen, TOTAL);
        check("queue_empty_at_done", q.size(), 0);
        done_count++;
        bits_seen = 0;
        prev_active = 0;
      end else if (!cs) begin
        if (q.size() == 0) begin
          check("unexpected_bit", cs, 1'b1);
        end else begin
          e = q.pop_front();
          check($sformatf("bit%0d", bits_seen), {dc, mosi}, e);
        end
        bits_seen++;
        prev_active = 1;
      end else begin
        if (prev_active) check("done_after_last_bit", done, 1'b1);
        prev_active = 0;
      end
    end
  end

  // Stimulus
  initial begin
    int saved;
    int n;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cs", cs, 1'b1);
    check("reset_mosi", mosi, 1'b0);
    check("reset_dc", dc, 1'b0);
    check("reset_done", done, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_cs_no_start", cs, 1'b1);
    check("idle_done_no_start", done, 1'b0);

    do_run(1'b0);
    do_run(1'b1);

    saved = done_count;
    push_expected();
    pulse_start_and_time();
    n = 0;
    while (bits_seen < 45 && n < 200) begin @(posedge clk); n++; end
    #3 rst = 1'b0;
    #1;
    check("async_reset_cs", cs, 1'b1);
    check("async_reset_mosi", mosi, 1'b0);
    check("async_reset_dc", dc, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_done_after_abort", done_count, saved);
    check("idle_after_abort", cs, 1'b1);

    do_run(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
